dataframe_arbiter: RTL
======================

DATAFRAME_ARBITER -- requirements
Module: dataframe_arbiter

Interface
REQ-001 Parameter N_CHANNEL, default 4: number of dataframe_generator streams merged; legal range 2..8.
REQ-002 Parameter DATA_WIDTH, default 128: per-beat TDATA width; TKEEP width is DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: mid-frame stall limit; used only when DATAFRAME_ARB_TIMEOUT_EN is defined.
REQ-004 Port list (name, direction, width, meaning):
- ACLK  in  1  sole clock.
- ARESET  in  1  reset; one clock; reset is synchronous and active-high.
- CHANNEL_ENABLE  in  N_CHANNEL  per-channel arbitration enable.
- S_AXIS_TDATA  in  N_CHANNEL*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- S_AXIS_TKEEP  in  N_CHANNEL*DATA_WIDTH/8  packed the same way as TDATA.
- S_AXIS_TVALID  in  N_CHANNEL  per-channel valid.
- S_AXIS_TLAST  in  N_CHANNEL  per-channel end of frame.
- S_AXIS_TREADY  out  N_CHANNEL  per-channel ready.
- M_AXIS_TDATA  out  DATA_WIDTH  merged stream data.
- M_AXIS_TKEEP  out  DATA_WIDTH/8  merged stream keep.
- M_AXIS_TVALID  out  1  merged stream valid.
- M_AXIS_TLAST  out  1  merged stream end of frame.
- M_AXIS_TREADY  in  1  downstream ready.
- GRANT_ID  out  3  index of the channel currently granted.
- ARB_ERROR  out  1  sticky error flag.

Function
REQ-005 Arbitration SHALL be frame-granular round-robin; once a channel is granted, it SHALL own the output until its TLAST beat handshakes.
REQ-006 FSM states SHALL be IDLE and STREAM, plus FLUSH when DATAFRAME_ARB_TIMEOUT_EN is defined.
REQ-007 In IDLE, the eligible set is S_AXIS_TVALID & CHANNEL_ENABLE.
- If the set is non-empty, the arbiter SHALL latch the first eligible channel at or after rr_ptr (with wrap-around) into GRANT_ID and enter STREAM on the next edge.
- If the set is empty, the FSM SHALL stay in IDLE.
REQ-008 In STREAM, the datapath SHALL be combinational (zero latency):
- M_AXIS_TDATA/TKEEP/TVALID/TLAST = S_AXIS_*[GRANT_ID].
- S_AXIS_TREADY[GRANT_ID] = M_AXIS_TREADY.
- All other S_AXIS_TREADY bits = 0.
REQ-009 On a handshake with M_AXIS_TLAST=1, the arbiter SHALL set rr_ptr = (GRANT_ID+1) mod N_CHANNEL and return to IDLE; exactly one arbitration bubble cycle SHALL occur between frames.
REQ-010 In IDLE, M_AXIS_TVALID and all S_AXIS_TREADY bits SHALL be 0.
REQ-011 Clearing CHANNEL_ENABLE for the granted channel mid-frame SHALL NOT truncate the frame; the change takes effect at the next arbitration.
REQ-012 M_AXIS_TVALID SHALL follow the granted source even when M_AXIS_TREADY=0; source data is never dropped or duplicated.
REQ-013 A single enabled, continuously valid channel SHALL be re-granted after each bubble cycle.
REQ-014 ARB_ERROR SHALL set if a granted channel presents TVALID=1 with TKEEP all-zero; the frame SHALL still pass unaltered.

Reset
REQ-015 While ARESET is high at a clock edge, the block SHALL reset to: state=IDLE, rr_ptr=0, GRANT_ID=0, ARB_ERROR=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, M_AXIS_TKEEP=0, S_AXIS_TREADY=0, and timeout counter=0.
REQ-016 A reset asserted mid-frame SHALL abandon the frame with no TLAST emitted; the downstream side is reset in the same domain.

Configuration
REQ-017 With DATAFRAME_ARB_TIMEOUT_EN defined, a stall counter SHALL count STREAM cycles where S_AXIS_TVALID[GRANT_ID]=0, and clear on any granted-valid cycle.
REQ-018 When the stall counter reaches TIMEOUT_CYCLES, the FSM SHALL enter FLUSH, which:
- drives one beat with TDATA=0, TKEEP=0, TLAST=1, TVALID=1;
- holds that beat until M_AXIS_TREADY;
- sets ARB_ERROR;
- advances rr_ptr;
- returns to IDLE.
REQ-019 Without DATAFRAME_ARB_TIMEOUT_EN defined, no counter or FLUSH state SHALL exist, and a stalled frame holds the grant indefinitely.

Structure
REQ-020 A shared package dataframe_arb_pkg SHALL hold the FSM state encoding, GRANT_ID width (3), and the default TIMEOUT_CYCLES.
REQ-021 A sub-module rr_select (N-bit request vector plus pointer, producing a one-hot and index output, combinational) SHALL implement the wrap-around search.
REQ-022 DATA_WIDTH SHALL match the dataframe config TDATA width used by the upstream generators.

Verification
REQ-023 Channels 0 and 2 valid, with 3-beat and 5-beat frames respectively, all enabled, rr_ptr=0 -> output is ch0 frame (3 beats), 1 bubble, then ch2 frame (5 beats); GRANT_ID 0 then 2.
REQ-024 All 4 channels continuously valid with 2-beat frames -> grant order 0,1,2,3,0; each frame is contiguous and every TLAST is preserved.
REQ-025 M_AXIS_TREADY toggles 1010 during a 4-beat ch1 frame -> 4 beats transferred over 8 cycles with data unchanged; S_AXIS_TREADY[1] mirrors TREADY and the other ready bits stay 0.
REQ-026 CHANNEL_ENABLE[1] cleared at beat 2 of a 4-beat ch1 frame -> all 4 beats are emitted; ch1 is skipped at the next arbitration.
REQ-027 DATAFRAME_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, ch3 TVALID held low after beat 1 -> after 16 stall cycles, one beat with TKEEP=0 and TLAST=1 is emitted, ARB_ERROR=1, and the next grant goes to ch0.
REQ-028 ARESET pulsed for 1 cycle mid-frame -> on the next cycle all outputs are at their reset values, and re-arbitration starts from ch0.

Source files
------------

// File: rtl/dataframe_arb_pkg.sv
// Shared definitions for the dataframe arbiter: FSM encoding, grant width, timeout default.
package dataframe_arb_pkg;

    localparam int GRANT_W                = 3;
    localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

    typedef logic [GRANT_W-1:0] grant_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

endpackage

// File: rtl/dataframe_arbiter_rr_select.sv
// rr_select: combinational wrap-around search for the first request at or after ptr.
module rr_select
    import dataframe_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  grant_t       ptr,
    output logic [N-1:0] grant_onehot,
    output grant_t       grant_idx
);

    localparam logic [N-1:0]     ONE    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [GRANT_W:0] N_WRAP = N[GRANT_W:0];

    logic [2*N-1:0]   req_dbl_s;
    logic [N-1:0]     req_rot_s;
    grant_t           sel_off_s;
    logic [GRANT_W:0] sum_s;

    // Rotate requests so ptr sits at bit 0, then take the lowest set offset.
    always_comb begin
        req_dbl_s = {req, req};
        req_rot_s = N'(req_dbl_s >> ptr);
        sel_off_s = '0;
        for (int j = N - 1; j >= 0; j--) begin
            sel_off_s = req_rot_s[j] ? grant_t'(j) : sel_off_s;
        end
        sum_s        = {1'b0, ptr} + {1'b0, sel_off_s};
        grant_idx    = (sum_s >= N_WRAP) ? grant_t'(sum_s - N_WRAP) : grant_t'(sum_s);
        grant_onehot = (|req) ? (ONE << grant_idx) : '0;
    end

endmodule

// File: rtl/dataframe_arbiter.sv
// Frame-granular round-robin merge of N_CHANNEL AXI-Stream sources into one output.
// Optional mid-frame stall timeout with FLUSH beat: define DATAFRAME_ARB_TIMEOUT_EN.
module dataframe_arbiter
    import dataframe_arb_pkg::*;
#(
    parameter int N_CHANNEL      = 4,
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [N_CHANNEL-1:0]              CHANNEL_ENABLE,
    input  logic [N_CHANNEL*DATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [N_CHANNEL*DATA_WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic [N_CHANNEL-1:0]              S_AXIS_TVALID,
    input  logic [N_CHANNEL-1:0]              S_AXIS_TLAST,
    output logic [N_CHANNEL-1:0]              S_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0]             M_AXIS_TDATA,
    output logic [DATA_WIDTH/8-1:0]           M_AXIS_TKEEP,
    output logic                              M_AXIS_TVALID,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY,
    output logic [2:0]                        GRANT_ID,
    output logic                              ARB_ERROR
);

    localparam int     KEEP_W  = DATA_WIDTH / 8;
    localparam grant_t LAST_CH = grant_t'(N_CHANNEL - 1);

    if (N_CHANNEL < 2 || N_CHANNEL > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("dataframe_arbiter: illegal parameter set");
    end

    logic [1:0] state_q, state_d;
    grant_t     grant_q, grant_d;
    grant_t     rr_ptr_q, rr_ptr_d;
    logic       arb_error_q, arb_error_d;

`ifdef DATAFRAME_ARB_TIMEOUT_EN
    localparam int               CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
`endif

    logic [N_CHANNEL-1:0]  pick_onehot_s;
    grant_t                pick_idx_s;
    logic                  pick_any_s;
    grant_t                next_ptr_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic [KEEP_W-1:0]     sel_keep_s;
    logic                  sel_valid_s;
    logic                  sel_last_s;

    rr_select #(.N(N_CHANNEL)) u_rr_select (
        .req          (S_AXIS_TVALID & CHANNEL_ENABLE),
        .ptr          (rr_ptr_q),
        .grant_onehot (pick_onehot_s),
        .grant_idx    (pick_idx_s)
    );

    assign pick_any_s = |pick_onehot_s;
    assign next_ptr_s = (grant_q == LAST_CH) ? '0 : grant_q + 3'd1;
    assign GRANT_ID   = grant_q;
    assign ARB_ERROR  = arb_error_q;

    // Select the granted source lanes.
    always_comb begin
        sel_data_s  = '0;
        sel_keep_s  = '0;
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        for (int i = 0; i < N_CHANNEL; i++) begin
            sel_data_s  = (grant_q == grant_t'(i)) ? S_AXIS_TDATA[i*DATA_WIDTH +: DATA_WIDTH] : sel_data_s;
            sel_keep_s  = (grant_q == grant_t'(i)) ? S_AXIS_TKEEP[i*KEEP_W +: KEEP_W] : sel_keep_s;
            sel_valid_s = (grant_q == grant_t'(i)) ? S_AXIS_TVALID[i] : sel_valid_s;
            sel_last_s  = (grant_q == grant_t'(i)) ? S_AXIS_TLAST[i] : sel_last_s;
        end
    end

    // Zero-latency output path; everything idles at zero outside STREAM/FLUSH.
    always_comb begin
        M_AXIS_TDATA  = '0;
        M_AXIS_TKEEP  = '0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        S_AXIS_TREADY = '0;
        case (state_q)
            ST_STREAM: begin
                M_AXIS_TDATA  = sel_data_s;
                M_AXIS_TKEEP  = sel_keep_s;
                M_AXIS_TVALID = sel_valid_s;
                M_AXIS_TLAST  = sel_last_s;
                S_AXIS_TREADY = {{(N_CHANNEL-1){1'b0}}, M_AXIS_TREADY} << grant_q;
            end
`ifdef DATAFRAME_ARB_TIMEOUT_EN
            ST_FLUSH: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TLAST  = 1'b1;
            end
`endif
            default: begin
                M_AXIS_TVALID = 1'b0;
            end
        endcase
    end

    // Arbitration FSM next-state logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        arb_error_d = arb_error_q;
`ifdef DATAFRAME_ARB_TIMEOUT_EN
        stall_cnt_d = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    grant_d = pick_idx_s;
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                arb_error_d = arb_error_q | (sel_valid_s & ~(|sel_keep_s));
`ifdef DATAFRAME_ARB_TIMEOUT_EN
                stall_cnt_d = sel_valid_s ? '0 : stall_cnt_q + CNT_W'(1);
`endif
                if (sel_valid_s && sel_last_s && M_AXIS_TREADY) begin
                    rr_ptr_d = next_ptr_s;
                    state_d  = ST_IDLE;
`ifdef DATAFRAME_ARB_TIMEOUT_EN
                end else if (!sel_valid_s && stall_cnt_q == STALL_LIMIT) begin
                    stall_cnt_d = '0;
                    arb_error_d = 1'b1;
                    state_d     = ST_FLUSH;
`endif
                end else begin
                    state_d = ST_STREAM;
                end
            end
`ifdef DATAFRAME_ARB_TIMEOUT_EN
            ST_FLUSH: begin
                if (M_AXIS_TREADY) begin
                    rr_ptr_d = next_ptr_s;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            arb_error_q <= 1'b0;
`ifdef DATAFRAME_ARB_TIMEOUT_EN
            stall_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            arb_error_q <= arb_error_d;
`ifdef DATAFRAME_ARB_TIMEOUT_EN
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

endmodule
